// File: rtl/rvc_fetch_align_queue.sv
// Instruction prefetch and realignment queue for an RVC-capable pipeline.
// Aligned 32-bit fetch words are split into halfwords (each tagged with its
// PC) and re-assembled at the head into 16-bit or 32-bit instructions,
// including 32-bit instructions that straddle a fetch word boundary.
module rvc_fetch_align_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  output logic [31:0] pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   hw_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   target_pc_q;
  logic          drop_pending_q;
  logic          outstanding_q;
  logic          started_q;

  logic [CW-1:0] free_slots;
  logic          ren;
  logic          complete;
  logic          push;
  logic          push_two;
  logic          pop;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [31:0]   word;
  logic [31:0]   redirect_target;
  logic [PW-1:0] rd_ptr_nx1;
  logic [PW-1:0] wr_ptr_nx1;
  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          head_c;
  logic          head_valid;

  // Cache delivers bytes in memory order; reverse them into instruction order.
  assign word            = {ICACHE_rdata[7:0], ICACHE_rdata[15:8],
                            ICACHE_rdata[23:16], ICACHE_rdata[31:24]};
  assign redirect_target = redirect_pc_i & ~32'h1;

  assign free_slots = CW'(DEPTH) - count_q;
  // Request only with room for a full word; keep requesting while stalled so
  // the cache sees a stable request. started_q keeps ren low in reset.
  assign ren        = started_q & ((free_slots >= CW'(2)) | outstanding_q);
  assign complete   = ren & ~ICACHE_stall;
  assign push       = complete & ~redirect_i & ~drop_pending_q;
  // A misaligned fetch PC (after a redirect to pc[1]=1) uses only the high half.
  assign push_two   = ~fetch_pc_q[1];
  assign push_n     = push ? (push_two ? CW'(2) : CW'(1)) : '0;

  assign rd_ptr_nx1 = rd_ptr_q + PW'(1);
  assign wr_ptr_nx1 = wr_ptr_q + PW'(1);
  assign h0         = hw_q[rd_ptr_q];
  assign h1         = hw_q[rd_ptr_nx1];
  assign head_c     = (h0[1:0] != 2'b11);
  assign head_valid = head_c ? (count_q >= CW'(1)) : (count_q >= CW'(2));
  assign pop        = head_valid & out_ready_i & ~redirect_i;
  assign pop_n      = pop ? (head_c ? CW'(1) : CW'(2)) : '0;

  assign ICACHE_ren      = ren;
  assign ICACHE_addr     = fetch_pc_q[31:2];
  assign out_valid_o     = head_valid;
  assign instr_o         = head_c ? {16'h0000, h0} : {h1, h0};
  assign pc_o            = pc_q[rd_ptr_q];
  assign is_compressed_o = (count_q != '0) & head_c;

  // Queue pointers, fetch PC and redirect/drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      fetch_pc_q     <= RESET_PC;
      target_pc_q    <= '0;
      drop_pending_q <= 1'b0;
      outstanding_q  <= 1'b0;
      started_q      <= 1'b0;
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= ren & ICACHE_stall;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        if (ren & ICACHE_stall) begin
          // Stalled request must stay on the bus; park the new target.
          drop_pending_q <= 1'b1;
          target_pc_q    <= redirect_target;
        end else begin
          drop_pending_q <= 1'b0;
          fetch_pc_q     <= redirect_target;
        end
      end else begin
        rd_ptr_q <= rd_ptr_q + PW'(pop_n);
        wr_ptr_q <= wr_ptr_q + PW'(push_n);
        count_q  <= count_q + push_n - pop_n;
        if (drop_pending_q & complete) begin
          drop_pending_q <= 1'b0;
          fetch_pc_q     <= target_pc_q;
        end else if (push) begin
          fetch_pc_q <= {fetch_pc_q[31:2] + 30'd1, 2'b00};
        end
      end
    end
  end

  // Halfword storage: write one or two halfwords with their PCs on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        hw_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (push) begin
      hw_q[wr_ptr_q] <= push_two ? word[15:0] : word[31:16];
      pc_q[wr_ptr_q] <= fetch_pc_q;
      if (push_two) begin
        hw_q[wr_ptr_nx1] <= word[31:16];
        pc_q[wr_ptr_nx1] <= fetch_pc_q + 32'd2;
      end
    end
  end

endmodule

// File: tb/tb_rvc_fetch_align_queue.sv
// Directed bench for rvc_fetch_align_queue: a table of expected output
// records per scenario plus hand-written reset/redirect/stall sequences.
module tb_rvc_fetch_align_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic        ICACHE_stall;
  logic [31:0] ICACHE_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic        is_compressed_o;
  logic [31:0] pc_o;

  rvc_fetch_align_queue #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
    .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .is_compressed_o(is_compressed_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  logic [29:0] addr_q[$];
  logic [31:0] prog[128];
  logic        stall_en;
  logic [29:0] stall_word;
  logic        hold_off;
  int          nvec = 0;
  int          nmis = 0;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Memory model: program words stored in instruction order.
  always_comb begin
    ICACHE_rdata = bswap(prog[ICACHE_addr[6:0]]);
    ICACHE_stall = stall_en && (ICACHE_addr == stall_word);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic add(input int id, input logic [31:0] pc, input logic [31:0] ins, input logic c);
    vec_t v;
    v.id = id; v.pc = pc; v.instr = ins; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic load(input int id);
    foreach (tbl[i]) if (tbl[i].id == id) exp_q.push_back(tbl[i]);
  endtask

  // One cycle: drive ready, observe the cycle's handshake and fetch, advance.
  task automatic tick();
    vec_t e;
    out_ready_i = !hold_off && (exp_q.size() != 0);
    #1;
    if (ICACHE_ren && !ICACHE_stall) addr_q.push_back(ICACHE_addr);
    if (out_valid_o && out_ready_i && !redirect_i) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_output: got pc=%h instr=%h want none", pc_o, instr_o);
      end else begin
        e = exp_q.pop_front();
        if (pc_o !== e.pc || instr_o !== e.instr || is_compressed_o !== e.c) begin
          nmis++;
          $display("FAIL out_t%0d: got pc=%h instr=%h c=%b want pc=%h instr=%h c=%b",
                   e.id, pc_o, instr_o, is_compressed_o, e.pc, e.instr, e.c);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
    nvec++;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout: got %0d outputs left want 0", exp_q.size());
    end
  endtask

  task automatic reset_low();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    out_ready_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_prog_a();
    for (int i = 0; i < 128; i++) prog[i] = 32'h0001_0001;
    for (int i = 0; i < 16; i++)
      prog[i] = {16'h4001 | 16'((2 * i + 1) << 4), 16'h4001 | 16'((2 * i) << 4)};
    prog[7'h40] = 32'h4565_4505;
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    out_ready_i = 1'b0;
    stall_en = 1'b0;
    stall_word = '0;
    hold_off = 1'b0;
    for (int i = 0; i < 128; i++) prog[i] = 32'h0001_0001;

    // Expected output records per scenario.
    add(1, 32'h0, 32'h0000_0013, 1'b0);
    add(1, 32'h4, 32'h0000_4505, 1'b1);
    add(1, 32'h6, 32'h0000_4501, 1'b1);
    add(2, 32'h0, 32'h0000_0001, 1'b1);
    add(2, 32'h2, 32'h0010_0093, 1'b0);
    for (int k = 0; k < 8; k++) add(3, 32'(2 * k), 32'h4001 | 32'(k << 4), 1'b1);
    add(4, 32'h102, 32'h0000_4565, 1'b1);
    add(4, 32'h104, 32'h0000_0001, 1'b1);
    add(5, 32'h100, 32'h0000_4505, 1'b1);
    add(5, 32'h102, 32'h0000_4565, 1'b1);
    add(60, 32'h0, 32'h0000_4001, 1'b1);
    add(6, 32'h0, 32'h0000_4001, 1'b1);
    add(6, 32'h2, 32'h0000_4011, 1'b1);

    // Reset state and basic stream.
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h4501_4505;
    reset_low();
    chk("rst_ren", 32'(ICACHE_ren), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_c", 32'(is_compressed_o), 32'h0);
    rst_n = 1'b1;
    addr_q.delete();
    load(1);
    drain(40);
    chk("t1_first_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 30'h3fff_ffff), 32'h0);

    // Straddling 32-bit instruction with the second word stalled.
    reset_low();
    prog[0] = 32'h0093_0001;
    prog[1] = 32'h0001_0010;
    stall_en = 1'b1;
    stall_word = 30'd1;
    rst_n = 1'b1;
    load(2);
    repeat (8) tick();
    chk("t2_remaining", 32'(exp_q.size()), 32'd1);
    chk("t2_valid_low", 32'(out_valid_o), 32'h0);
    chk("t2_head_pc", pc_o, 32'h2);
    stall_en = 1'b0;
    drain(40);

    // Backpressure: queue fills after exactly four fetches.
    reset_low();
    fill_prog_a();
    hold_off = 1'b1;
    rst_n = 1'b1;
    addr_q.delete();
    repeat (20) tick();
    chk("t3_fetches", 32'(addr_q.size()), 32'd4);
    chk("t3_ren_off", 32'(ICACHE_ren), 32'h0);
    load(3);
    hold_off = 1'b0;
    drain(60);

    // Redirect to a misaligned halfword target.
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    addr_q.delete();
    load(4);
    drain(40);
    chk("t4_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 30'h3fff_ffff), 32'h40);

    // Redirect while a request is stalled.
    reset_low();
    stall_en = 1'b1;
    stall_word = 30'd1;
    hold_off = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !(ICACHE_ren && ICACHE_stall); i++) tick();
    chk("t5_stalled", 32'(ICACHE_ren && ICACHE_stall), 32'h1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr_hold", 32'(ICACHE_addr), 32'h1);
      chk("t5_ren_hold", 32'(ICACHE_ren), 32'h1);
      tick();
    end
    addr_q.delete();
    load(5);
    stall_en = 1'b0;
    hold_off = 1'b0;
    drain(40);
    chk("t5_drop_addr", 32'(addr_q.size() > 1 ? addr_q[0] : 30'h3fff_ffff), 32'h1);
    chk("t5_new_addr", 32'(addr_q.size() > 1 ? addr_q[1] : 30'h3fff_ffff), 32'h40);

    // Asynchronous reset mid-stream with five halfwords queued.
    reset_low();
    stall_en = 1'b1;
    stall_word = 30'd3;
    hold_off = 1'b1;
    rst_n = 1'b1;
    repeat (15) tick();
    load(60);
    hold_off = 1'b0;
    drain(10);
    chk("t6_pre_valid", 32'(out_valid_o), 32'h1);
    chk("t6_pre_pc", pc_o, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ren", 32'(ICACHE_ren), 32'h0);
    chk("t6_rst_valid", 32'(out_valid_o), 32'h0);
    chk("t6_rst_instr", instr_o, 32'h0);
    chk("t6_rst_pc", pc_o, 32'h0);
    chk("t6_rst_c", 32'(is_compressed_o), 32'h0);
    chk("t6_rst_addr", 32'(ICACHE_addr), 32'h0);
    stall_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    addr_q.delete();
    load(6);
    drain(40);
    chk("t6_restart_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 30'h3fff_ffff), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
